// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive lane controller:
// alignment symbol default, state encoding and lane count.
package phy_rx_pkg;

  localparam logic [7:0] COM_DEFAULT = 8'hBC;
  localparam int         NUM_LANES   = 4;
  localparam int         LANE_W      = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    ST_RESET   = 2'b00,
    ST_SEARCH  = 2'b01,
    ST_ALIGNED = 2'b10
  } rx_state_e;

endpackage

// File: rtl/phy_rx_lane_ctrl.sv
// Byte-lane alignment/distribution: locks on a run of COM symbols, then
// deals data bytes round-robin to lanes 0..3 with a one-hot write strobe.
// Ports: clk_4f, reset (sync, active-high), data_in/valid_in in;
// data_out, lane_sel, lane_we, active, state, err out (all registered).
module phy_rx_lane_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM      = COM_DEFAULT,
  parameter int         LOCK_CNT = 4,
  parameter int         ERR_MAX  = 3
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  output logic [7:0]           data_out,
  output logic [LANE_W-1:0]    lane_sel,
  output logic [NUM_LANES-1:0] lane_we,
  output logic                 active,
  output logic [1:0]           state,
  output logic                 err
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  localparam logic [CW-1:0] COM_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] COM_SAT  = CW'(LOCK_CNT);
  localparam logic [EW-1:0] ERR_LAST = EW'(ERR_MAX - 1);
  localparam logic [EW-1:0] ERR_SAT  = EW'(ERR_MAX);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         com_q, com_d;
  logic [EW-1:0]         errc_q, errc_d;
  logic [LANE_W-1:0]     sel_q, sel_d;
  logic [7:0]            dout_q, dout_d;
  logic [NUM_LANES-1:0]  we_q, we_d;
  logic                  err_q, err_d;

  logic is_com;
  assign is_com = (data_in == COM);

  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    errc_d  = errc_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    we_d    = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_SEARCH;
      ST_SEARCH: begin
        if (valid_in) begin
          if (!is_com) begin
            com_d = '0;
          end else if (com_q == COM_LAST) begin
            state_d = ST_ALIGNED;
            sel_d   = '0;
            errc_d  = '0;
            com_d   = '0;
          end else if (com_q != COM_SAT) begin
            com_d = com_q + 1'b1;
          end
        end
      end
      ST_ALIGNED: begin
        if (valid_in) begin
          if (!is_com) begin
            dout_d       = data_in;
            we_d[sel_q]  = 1'b1;
            sel_d        = sel_q + 1'b1;
            if (sel_q == LANE_LAST) errc_d = '0;
          end else if (sel_q != '0) begin
            // COM inside a partial group: abandon the group
            err_d = 1'b1;
            sel_d = '0;
            if (errc_q != ERR_SAT) errc_d = errc_q + 1'b1;
            if (errc_q == ERR_LAST) state_d = ST_SEARCH;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= ST_RESET;
      com_q   <= '0;
      errc_q  <= '0;
      sel_q   <= '0;
      dout_q  <= '0;
      we_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      com_q   <= com_d;
      errc_q  <= errc_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign data_out = dout_q;
  assign lane_sel = sel_q;
  assign lane_we  = we_q;
  assign err      = err_q;
  assign state    = state_q;
  assign active   = (state_q == ST_ALIGNED);

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Self-checking bench for phy_rx_lane_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a reference model.
module tb_phy_rx_lane_ctrl;

  localparam logic [7:0] COM = 8'hBC;
  localparam int LOCK = 4;
  localparam int ERRM = 3;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic [1:0] lane_sel;
  logic [3:0] lane_we;
  logic       active;
  logic [1:0] state;
  logic       err;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: mode 0=reset,1=search,2=aligned
  int m_mode = 0;
  int m_run = 0;
  int m_lane = 0;
  int m_errs = 0;
  int m_we = 0;
  int m_dout = 0;
  int m_err = 0;

  phy_rx_lane_ctrl #(.COM(COM), .LOCK_CNT(LOCK), .ERR_MAX(ERRM)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .data_out(data_out), .lane_sel(lane_sel),
    .lane_we(lane_we), .active(active), .state(state), .err(err)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input int d);
    m_we = 0;
    m_err = 0;
    if (r) begin
      m_mode = 0; m_run = 0; m_lane = 0; m_errs = 0; m_dout = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (v) begin
        m_run = (d == COM) ? m_run + 1 : 0;
        if (m_run >= LOCK) begin
          m_mode = 2; m_run = 0; m_lane = 0; m_errs = 0;
        end
      end
    end else if (v) begin
      if (d != COM) begin
        m_dout = d;
        m_we = 1 << m_lane;
        if (m_lane == 3) m_errs = 0;
        m_lane = (m_lane + 1) % 4;
      end else if (m_lane != 0) begin
        m_err = 1;
        m_lane = 0;
        m_errs++;
        if (m_errs >= ERRM) m_mode = 1;
      end
    end
  endtask

  task automatic compare();
    int exp_st;
    exp_st = (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : 2;
    chk("state", state, exp_st);
    chk("active", active, m_mode == 2);
    chk("lane_sel", lane_sel, m_lane);
    chk("lane_we", lane_we, m_we);
    chk("err", err, m_err);
    if (m_we != 0) chk("data_out", data_out, m_dout);
    else chk("data_out_hold", data_out, m_dout);
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] d);
    reset = r;
    valid_in = v;
    data_in = d;
    @(posedge clk_4f);
    model(r, v, int'(d));
    #1;
    compare();
  endtask

  task automatic restart();
    cyc(1, 0, 8'h00);
    cyc(0, 0, 8'h00);
  endtask

  task automatic lock();
    repeat (LOCK) cyc(0, 1, COM);
  endtask

  initial begin
    logic [7:0] seq [];
    int heavy;
    logic [7:0] d;

    // reset held, released idle
    repeat (3) cyc(1, 0, 8'h00);
    chk("rst_state", state, 0);
    chk("rst_we", lane_we, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_err", err, 0);
    cyc(0, 0, 8'h00);
    chk("post_rst_state", state, 1);

    // lock then five data bytes
    lock();
    chk("lock_active", active, 1);
    chk("lock_state", state, 2);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 8'(i));
      chk("rr_we", lane_we, 1 << ((i - 1) % 4));
      chk("rr_dout", data_out, i);
    end

    // broken COM run delays lock
    restart();
    seq = '{8'hBC, 8'hBC, 8'h7C, 8'hBC, 8'hBC, 8'hBC};
    foreach (seq[i]) cyc(0, 1, seq[i]);
    chk("nolock_state", state, 1);
    cyc(0, 1, 8'hBC);
    chk("late_lock_state", state, 2);

    // error in partial group
    cyc(0, 1, 8'hAA);
    cyc(0, 1, 8'hBB);
    cyc(0, 1, 8'hBC);
    chk("perr_err", err, 1);
    chk("perr_sel", lane_sel, 0);
    chk("perr_we", lane_we, 0);
    cyc(0, 1, 8'hCC);
    chk("perr_next_we", lane_we, 4'b0001);
    chk("perr_next_dout", data_out, 8'hCC);

    // repeated errors force relock
    restart();
    lock();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 8'hAA);
      cyc(0, 1, 8'hBC);
      chk("rep_err", err, 1);
      chk("rep_state", state, (i == 2) ? 1 : 2);
    end
    chk("relock_active", active, 0);

    // gap mid-group, then reset mid-group
    restart();
    lock();
    cyc(0, 1, 8'hAA);
    chk("gap_we0", lane_we, 4'b0001);
    repeat (5) cyc(0, 0, 8'h55);
    chk("gap_idle_we", lane_we, 0);
    cyc(0, 1, 8'hBB);
    chk("gap_we1", lane_we, 4'b0010);
    chk("gap_err", err, 0);
    cyc(1, 1, 8'hCC);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_sel", lane_sel, 0);
    cyc(0, 1, 8'hBC);
    cyc(0, 1, 8'h11);
    chk("need_relock_we", lane_we, 0);
    chk("need_relock_state", state, 1);

    // randomized traffic
    heavy = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 48 == 0) heavy = $urandom_range(0, 1);
      if (heavy != 0)
        d = ($urandom_range(0, 9) < 9) ? COM : 8'($urandom);
      else
        d = ($urandom_range(0, 6) == 0) ? COM : 8'($urandom);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
